// File: rtl/bank_fifo_pkg.sv
// rtl/bank_fifo_pkg.sv - shared widths, types and block-compare helper for bank_fifo_ctrl
`timescale 1ns/1ps
package bank_fifo_pkg;
    localparam int ADDR_W  = 11;
    localparam int PTR_W   = ADDR_W + 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int BLK_LSB = 7;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [7:0]        data_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
        data_t data;
    } pend_t;

    function automatic logic same_block(input addr_t a, input addr_t b);
        return a[ADDR_W-1:BLK_LSB] == b[ADDR_W-1:BLK_LSB];
    endfunction
endpackage

// File: rtl/bank_fifo_if.sv
// rtl/bank_fifo_if.sv - push/pop stream plus memory port bundle for bank_fifo_ctrl
`timescale 1ns/1ps
interface bank_fifo_if;
    import bank_fifo_pkg::*;

    logic  push;
    data_t din;
    logic  pop;
    data_t dout;
    logic  dout_valid;
    logic  full;
    logic  empty;
    ptr_t  count;
    logic  mem_wen;
    addr_t mem_waddr;
    data_t mem_din;
    logic  mem_ren;
    addr_t mem_raddr;
    data_t mem_dout;

    modport slave (
        input  push, din, pop, mem_dout,
        output dout, dout_valid, full, empty, count,
        output mem_wen, mem_waddr, mem_din, mem_ren, mem_raddr
    );

    modport master (
        output push, din, pop, mem_dout,
        input  dout, dout_valid, full, empty, count,
        input  mem_wen, mem_waddr, mem_din, mem_ren, mem_raddr
    );
endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer counter with increment enable
`timescale 1ns/1ps
module fifo_ptr #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_nxt
);
    assign ptr_nxt = ptr + {{(W-1){1'b0}}, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end
endmodule

// File: rtl/bank_fifo_ctrl.sv
// rtl/bank_fifo_ctrl.sv - 2048x8 FIFO controller over a banked memory with one-entry write deferral
`timescale 1ns/1ps
module bank_fifo_ctrl
    import bank_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    bank_fifo_if.slave bus
);
    logic  push_acc, pop_acc;
    logic  w_valid, conflict;
    addr_t w_addr, rd_addr;
    data_t w_data;
    ptr_t  wr_ptr, wr_nxt, rd_ptr, rd_nxt;
    ptr_t  cnt_nxt, commit_nxt;
    pend_t pend, pend_nxt;
    logic  full_q, empty_q;
    ptr_t  count_q;
    logic  rd_inflight, rd_capture;
    data_t dout_q;

    // Gating by rst_n keeps the memory port idle while reset is held.
    assign push_acc = rst_n && bus.push && !full_q;
    assign pop_acc  = rst_n && bus.pop  && !empty_q;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (push_acc),
        .ptr     (wr_ptr),
        .ptr_nxt (wr_nxt)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pop_acc),
        .ptr     (rd_ptr),
        .ptr_nxt (rd_nxt)
    );

    always_comb begin
        w_valid  = pend.valid || push_acc;
        w_addr   = pend.valid ? pend.addr : wr_ptr[ADDR_W-1:0];
        w_data   = pend.valid ? pend.data : bus.din;
        rd_addr  = rd_ptr[ADDR_W-1:0];
        conflict = w_valid && pop_acc && same_block(w_addr, rd_addr);

        // The read always wins a block clash; the write waits in the pending slot.
        pend_nxt = '0;
        if (conflict) begin
            pend_nxt.valid = 1'b1;
            pend_nxt.addr  = w_addr;
            pend_nxt.data  = w_data;
        end

        cnt_nxt    = wr_nxt - rd_nxt;
        commit_nxt = wr_nxt - ptr_t'(pend_nxt.valid);
    end

    assign bus.mem_wen   = w_valid && !conflict;
    assign bus.mem_waddr = bus.mem_wen ? w_addr : '0;
    assign bus.mem_din   = bus.mem_wen ? w_data : '0;
    assign bus.mem_ren   = pop_acc;
    assign bus.mem_raddr = pop_acc ? rd_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            count_q     <= '0;
            rd_inflight <= 1'b0;
            rd_capture  <= 1'b0;
            dout_q      <= '0;
        end else begin
            pend        <= pend_nxt;
            full_q      <= (cnt_nxt == ptr_t'(DEPTH)) || pend_nxt.valid;
            empty_q     <= (rd_nxt == commit_nxt);
            count_q     <= cnt_nxt;
            rd_inflight <= pop_acc;
            rd_capture  <= rd_inflight;
            if (rd_inflight) dout_q <= bus.mem_dout;
        end
    end

    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.count      = count_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = rd_capture;
endmodule

// File: tb/tb_bank_fifo_ctrl.sv
// tb/tb_bank_fifo_ctrl.sv - directed scoreboard bench for bank_fifo_ctrl with a banked memory model
`timescale 1ns/1ps
module tb_bank_fifo_ctrl;
    import bank_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_count = 0;
    int   pushed;
    logic push_ok, pop_ok;
    data_t sb[$];
    int    lat_q[$];
    data_t mem [DEPTH];

    bank_fifo_if f();

    bank_fifo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Banked memory: registered read, a same-block write+read drops the read to 0.
    always @(posedge clk) begin
        if (f.mem_wen) mem[f.mem_waddr] <= f.mem_din;
        if (f.mem_ren)
            f.mem_dout <= (f.mem_wen && same_block(f.mem_waddr, f.mem_raddr)) ? 8'h00 : mem[f.mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && f.dout_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_dout_valid", f.dout_valid, 0);
            end else begin
                data_t ed;
                int    ec;
                ed = sb.pop_front();
                ec = lat_q.pop_front();
                chk("dout_data", f.dout, ed);
                chk("pop_latency", cyc, ec + 2);
            end
        end
    end

    task automatic drive(input logic ps, input data_t d, input logic pp);
        f.push = ps;
        f.din  = d;
        f.pop  = pp;
        #1;
        push_ok = rst_n && ps && !f.full;
        pop_ok  = rst_n && pp && !f.empty;
        if (push_ok) begin sb.push_back(d); exp_count++; end
        if (pop_ok)  begin lat_q.push_back(cyc); exp_count--; end
        if (f.mem_wen && f.mem_ren)
            chk("blk_conflict", same_block(f.mem_waddr, f.mem_raddr), 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 4000 && !f.empty; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        repeat (4) tick();
        chk({tag, "_empty"}, f.empty, 1);
        chk({tag, "_count"}, f.count, 0);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        f.push = 1'b0; f.din = '0; f.pop = 1'b0; f.mem_dout = '0;

        // Reset state, with requests asserted to show the memory port stays idle.
        @(negedge clk);
        drive(1'b1, 8'hAA, 1'b1);
        chk("rst_full", f.full, 0);
        chk("rst_empty", f.empty, 1);
        chk("rst_count", f.count, 0);
        chk("rst_dout_valid", f.dout_valid, 0);
        chk("rst_dout", f.dout, 0);
        chk("rst_mem_wen", f.mem_wen, 0);
        chk("rst_mem_ren", f.mem_ren, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();

        // Basic push/pop.
        drive(1'b1, 8'h11, 1'b0);
        chk("t2_empty_before", f.empty, 1);
        tick();
        chk("t2_empty_after_push", f.empty, 0);
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        chk("t2_count3", f.count, 3);
        for (int i = 0; i < 3; i++) begin drive(1'b0, 8'h00, 1'b1); tick(); end
        drain("t2");

        // Block conflict: rd_ptr=3, ten entries at 3..12, conflicting push at 13.
        for (int i = 0; i < 10; i++) begin drive(1'b1, 8'h40 + 8'(i), 1'b0); tick(); end
        drive(1'b1, 8'hC5, 1'b1);
        chk("t3_conf_ren", f.mem_ren, 1);
        chk("t3_conf_wen", f.mem_wen, 0);
        tick();
        chk("t3_full_p", f.full, 1);
        chk("t3_count", f.count, 10);
        drive(1'b0, 8'h00, 1'b0);
        chk("t3_p_wen", f.mem_wen, 1);
        chk("t3_p_waddr", f.mem_waddr, 13);
        chk("t3_p_din", f.mem_din, 8'hC5);
        tick();
        chk("t3_full_clear", f.full, 0);
        drain("t3");

        // Fill to DEPTH, overflow push, then push+pop while full.
        for (int i = 0; i < DEPTH; i++) begin drive(1'b1, 8'($urandom), 1'b0); tick(); end
        chk("t4_full", f.full, 1);
        chk("t4_count", f.count, DEPTH);
        drive(1'b1, 8'hEE, 1'b0);
        chk("t4_extra_wen", f.mem_wen, 0);
        tick();
        chk("t4_count_hold", f.count, DEPTH);
        drive(1'b1, 8'hEF, 1'b1);
        chk("t4_fp_wen", f.mem_wen, 0);
        chk("t4_fp_ren", f.mem_ren, 1);
        tick();
        chk("t4_fp_count", f.count, DEPTH - 1);
        chk("t4_fp_full", f.full, 0);
        drain("t4");

        // Streaming across pointer wrap at a depth of about 64.
        pushed = 0;
        for (int c = 0; c < 8000 && pushed < 3000; c++) begin
            drive(1'b1, 8'($urandom), exp_count >= 64);
            if (push_ok) pushed++;
            tick();
        end
        chk("t5_pushed", pushed, 3000);
        chk("t5_count", f.count, exp_count);
        drain("t5");

        // Pop on empty, then push+pop at count 0.
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_empty_ren", f.mem_ren, 0);
        tick();
        repeat (3) tick();
        drive(1'b1, 8'h77, 1'b1);
        chk("t6_pp_ren", f.mem_ren, 0);
        chk("t6_pp_wen", f.mem_wen, 1);
        tick();
        chk("t6_pp_empty", f.empty, 0);
        chk("t6_pp_count", f.count, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_pop_ren", f.mem_ren, 1);
        tick();
        drain("t6");

        // Reset with a read in flight and the pending slot occupied.
        rst_n = 1'b0;
        sb.delete(); lat_q.delete(); exp_count = 0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin drive(1'b1, 8'h90 + 8'(i), 1'b0); tick(); end
        drive(1'b1, 8'hA7, 1'b1);
        chk("t7_conf_wen", f.mem_wen, 0);
        tick();
        chk("t7_p_full", f.full, 1);
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("t7_rst_full", f.full, 0);
        chk("t7_rst_empty", f.empty, 1);
        chk("t7_rst_count", f.count, 0);
        chk("t7_rst_dout_valid", f.dout_valid, 0);
        chk("t7_rst_wen", f.mem_wen, 0);
        chk("t7_rst_ren", f.mem_ren, 0);
        sb.delete(); lat_q.delete(); exp_count = 0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t7_post_count", f.count, 0);
        chk("t7_post_empty", f.empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
